// File: rtl/mem_arbiter.sv
// mem_arbiter: single-port RAM arbiter, data over fetch; define STARVE_GUARD_EN to force fetch after STARVE_LIMIT denied cycles
module mem_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_gnt,
  output logic        i_rvalid,
  output logic [31:0] i_rdata,
  input  logic        d_req,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_we,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        mem_ce,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_we,
  input  logic [31:0] mem_rdata
);
  typedef enum logic [1:0] {IDLE, I_RD, D_RD} owner_t;
  owner_t owner;
  logic force_i;
  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_limit
    $error("mem_arbiter: STARVE_LIMIT out of range 1..15");
  end
`ifdef STARVE_GUARD_EN
  logic [3:0] starve_cnt;
  assign force_i = i_req && starve_cnt == 4'(STARVE_LIMIT);
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) starve_cnt <= '0;
    else if (i_gnt) starve_cnt <= '0;
    else if (i_req && starve_cnt != 4'(STARVE_LIMIT)) starve_cnt <= starve_cnt + 4'd1;
  end
`else
  assign force_i = 1'b0;
`endif
  always_comb begin
    d_gnt     = d_req && !force_i;
    i_gnt     = i_req && !d_gnt;
    mem_ce    = i_gnt || d_gnt;
    mem_addr  = i_gnt ? (i_addr & ~32'h3) : d_gnt ? (d_addr & ~32'h3) : 32'h0;
    mem_wdata = d_gnt ? d_wdata : 32'h0;
    mem_we    = d_gnt ? d_we : 4'h0;
    i_rvalid  = owner == I_RD;
    d_rvalid  = owner == D_RD;
    i_rdata   = i_rvalid ? mem_rdata : 32'h0;
    d_rdata   = d_rvalid ? mem_rdata : 32'h0;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) owner <= IDLE;
    else owner <= i_gnt ? I_RD : (d_gnt && d_we == 4'h0) ? D_RD : IDLE;
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed checks of grant, routing, read return, starvation and reset behaviour
module tb_mem_arbiter;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        i_req = 1'b0;
  logic [31:0] i_addr = '0;
  logic        i_gnt, i_rvalid;
  logic [31:0] i_rdata;
  logic        d_req = 1'b0;
  logic [31:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic [3:0]  d_we = '0;
  logic        d_gnt, d_rvalid;
  logic [31:0] d_rdata;
  logic        mem_ce;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_we;
  logic [31:0] mem_rdata = '0;
  int n_run = 0;
  int n_fail = 0;

  mem_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_addr(d_addr), .d_wdata(d_wdata), .d_we(d_we),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_ce(mem_ce), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    #1;
    chk("rst_i_rvalid", 32'(i_rvalid), 32'd0);
    chk("rst_d_rvalid", 32'(d_rvalid), 32'd0);
    chk("rst_i_rdata", i_rdata, 32'd0);
    chk("rst_mem_ce", 32'(mem_ce), 32'd0);
    @(negedge clk); rst = 1'b1;

    @(negedge clk); i_req = 1'b1; i_addr = 32'h0000_0106;
    #1;
    chk("f_i_gnt", 32'(i_gnt), 32'd1);
    chk("f_d_gnt", 32'(d_gnt), 32'd0);
    chk("f_mem_addr", mem_addr, 32'h0000_0104);
    chk("f_mem_we", 32'(mem_we), 32'd0);
    @(negedge clk); i_req = 1'b0; mem_rdata = 32'hCAFE_0001;
    #1;
    chk("f_i_rvalid", 32'(i_rvalid), 32'd1);
    chk("f_i_rdata", i_rdata, 32'hCAFE_0001);
    chk("f_d_rvalid", 32'(d_rvalid), 32'd0);
    chk("f_d_rdata", d_rdata, 32'd0);
    chk("f_idle_ce", 32'(mem_ce), 32'd0);

    @(negedge clk); i_req = 1'b1; i_addr = 32'h0000_0300; d_req = 1'b1; d_addr = 32'h0000_0200; d_we = 4'h0;
    #1;
    chk("pr_d_gnt", 32'(d_gnt), 32'd1);
    chk("pr_i_gnt", 32'(i_gnt), 32'd0);
    chk("pr_mem_addr", mem_addr, 32'h0000_0200);
    @(negedge clk); d_req = 1'b0; mem_rdata = 32'h1234_5678;
    #1;
    chk("pr_d_rvalid", 32'(d_rvalid), 32'd1);
    chk("pr_d_rdata", d_rdata, 32'h1234_5678);
    chk("pr_i_rdata0", i_rdata, 32'd0);
    chk("pr_i_gnt2", 32'(i_gnt), 32'd1);
    chk("pr_mem_addr2", mem_addr, 32'h0000_0300);
    @(negedge clk); i_req = 1'b0; mem_rdata = 32'h0000_0055;
    #1;
    chk("b2b_i_rvalid", 32'(i_rvalid), 32'd1);
    chk("b2b_i_rdata", i_rdata, 32'h0000_0055);
    chk("b2b_d_rvalid", 32'(d_rvalid), 32'd0);

    @(negedge clk); d_req = 1'b1; d_addr = 32'h0000_0040; d_we = 4'b0011; d_wdata = 32'h0000_BEEF;
    #1;
    chk("st_d_gnt", 32'(d_gnt), 32'd1);
    chk("st_mem_we", 32'(mem_we), 32'h3);
    chk("st_mem_wdata", mem_wdata, 32'h0000_BEEF);
    chk("st_mem_addr", mem_addr, 32'h0000_0040);
    @(negedge clk); d_req = 1'b0; d_we = 4'h0; mem_rdata = 32'hDEAD_0000;
    #1;
    chk("st_no_d_rvalid", 32'(d_rvalid), 32'd0);
    chk("st_no_i_rvalid", 32'(i_rvalid), 32'd0);
    chk("st_d_rdata0", d_rdata, 32'd0);
    chk("st_idle_wdata", mem_wdata, 32'd0);

    for (int c = 0; c < 6; c++) begin
      @(negedge clk); i_req = 1'b1; i_addr = 32'h0000_0800; d_req = 1'b1; d_addr = 32'h0000_0900;
      #1;
`ifdef STARVE_GUARD_EN
      chk($sformatf("sv_d_gnt_c%0d", c), 32'(d_gnt), (c == 4) ? 32'd0 : 32'd1);
      chk($sformatf("sv_i_gnt_c%0d", c), 32'(i_gnt), (c == 4) ? 32'd1 : 32'd0);
`else
      chk($sformatf("sv_d_gnt_c%0d", c), 32'(d_gnt), 32'd1);
      chk($sformatf("sv_i_gnt_c%0d", c), 32'(i_gnt), 32'd0);
`endif
    end
    @(negedge clk); i_req = 1'b0; d_req = 1'b0;

    @(negedge clk); i_req = 1'b1; d_req = 1'b1; d_we = 4'h0; mem_rdata = 32'hA5A5_A5A5;
    @(posedge clk); #3; rst = 1'b0;
    #1;
    chk("ar_d_rvalid", 32'(d_rvalid), 32'd0);
    chk("ar_d_rdata", d_rdata, 32'd0);
    chk("ar_i_rvalid", 32'(i_rvalid), 32'd0);
`ifdef STARVE_GUARD_EN
    chk("ar_cnt", 32'(dut.starve_cnt), 32'd0);
`endif
    @(negedge clk); d_req = 1'b0;
    @(negedge clk); rst = 1'b1; i_req = 1'b0;
    #1;
    chk("ar_post_i_rvalid", 32'(i_rvalid), 32'd0);
    chk("ar_post_d_rvalid", 32'(d_rvalid), 32'd0);
    @(negedge clk); #1;
    chk("ar_post2_i_rvalid", 32'(i_rvalid), 32'd0);

    @(negedge clk); i_req = 1'b1; i_addr = 32'h0000_0013;
    #1;
    chk("rec_mem_addr", mem_addr, 32'h0000_0010);
    @(negedge clk); i_req = 1'b0; mem_rdata = 32'h0BAD_F00D;
    #1;
    chk("rec_i_rdata", i_rdata, 32'h0BAD_F00D);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4, meaning the number of consecutive un-granted fetch-request cycles before fetch is forced ahead (range 1..15).
REQ-002 SHALL have port clk  input  1  clock, all state updates on the rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-low (0 = reset asserted).
REQ-004 SHALL have port i_req  input  1  fetch read request, held by the requester until granted.
REQ-005 SHALL have port i_addr  input  32  fetch byte address.
REQ-006 SHALL have port i_gnt  output  1  fetch request accepted this cycle.
REQ-007 SHALL have port i_rvalid  output  1  fetch read data valid.
REQ-008 SHALL have port i_rdata  output  32  fetch read data.
REQ-009 SHALL have port d_req  input  1  data request (load or store), held until granted.
REQ-010 SHALL have port d_addr  input  32  data byte address.
REQ-011 SHALL have port d_wdata  input  32  store data, already lane-aligned.
REQ-012 SHALL have port d_we  input  4  byte write enables; 0 means read.
REQ-013 SHALL have port d_gnt  output  1  data request accepted this cycle.
REQ-014 SHALL have port d_rvalid  output  1  load data valid.
REQ-015 SHALL have port d_rdata  output  32  load data.
REQ-016 SHALL have port mem_ce  output  1  single-port RAM access enable.
REQ-017 SHALL have port mem_addr  output  32  RAM word address, forced to {addr[31:2],2'b00}.
REQ-018 SHALL have port mem_wdata  output  32  RAM write data.
REQ-019 SHALL have port mem_we  output  4  RAM byte write enables.
REQ-020 SHALL have port mem_rdata  input  32  RAM read data, valid one cycle after the read access.

Function
REQ-021 SHALL grant combinationally in the request cycle: at most one of i_gnt/d_gnt high per cycle, and mem_ce equals i_gnt|d_gnt.
REQ-022 SHALL drive mem_addr/mem_wdata/mem_we from the granted requester; with fetch granted mem_we=0; with no grant mem_addr=0, mem_wdata=0, mem_we=0.
REQ-023 SHALL give data priority over fetch when both request, unless the starvation override of REQ-028 applies.
REQ-024 SHALL hold an owner register with states IDLE, I_RD, D_RD; it SHALL go to I_RD on a fetch grant, to D_RD on a data grant with d_we=0, and to IDLE otherwise, including a data write grant.
REQ-025 SHALL assert i_rvalid (state I_RD) or d_rvalid (state D_RD) exactly one cycle after the grant, with the matching rdata equal to mem_rdata; the other rdata output SHALL be 0.
REQ-026 SHALL not return data for writes: a write completes in its grant cycle and produces no rvalid.
REQ-027 SHALL sustain back-to-back grants, one per cycle, with no idle cycle between a read and the next access.

Reset
REQ-029 SHALL on rst=0 immediately force the owner to IDLE, the starvation counter to 0, and i_rvalid, d_rvalid, i_rdata and d_rdata to 0, independent of clk.
REQ-030 SHALL suppress rvalid for any read granted in the cycle in which reset is asserted; grant outputs remain combinational from the requests while rst=1.

Configuration
REQ-028 SHALL, when macro STARVE_GUARD_EN is defined, keep a 4-bit counter that increments each cycle i_req=1 and i_gnt=0, saturates at STARVE_LIMIT, and clears on i_gnt; while the counter equals STARVE_LIMIT and i_req=1, fetch SHALL win over data.
REQ-031 SHALL, without STARVE_GUARD_EN, contain no counter and apply strict data-over-fetch priority in every cycle; parameter STARVE_LIMIT is then ignored.

Verification
REQ-032 SHALL cover: i_req alone, i_addr=0x0000_0106 -> i_gnt=1, mem_addr=0x0000_0104, next cycle i_rvalid=1 with i_rdata=mem_rdata and d_rvalid=0.
REQ-033 SHALL cover: i_req and d_req (load 0x200) in the same cycle -> d_gnt=1, i_gnt=0; next cycle d_rvalid=1, and with d_req dropped, i_gnt=1.
REQ-034 SHALL cover: store d_we=4'b0011, d_wdata=0x0000_BEEF at 0x40 -> mem_we=0011, mem_wdata=0x0000_BEEF, and no rvalid in the following cycle.
REQ-035 SHALL cover, with STARVE_GUARD_EN and STARVE_LIMIT=4: d_req and i_req both held high -> d_gnt in cycles 0-3, i_gnt in cycle 4, d_gnt again in cycle 5; without the macro -> d_gnt in every cycle.
REQ-036 SHALL cover: read granted, then rst=0 asynchronously mid-cycle -> rvalid=0 at once and no rvalid after rst returns to 1; counter reads 0.
